// File: rtl/fpdiv_seq_ctrl.sv
// Sequencer for the Goldschmidt divider datapath: seed, ITERS refinement pairs, remainder, done.
// Optional macro FPDIV_SEQ_ABORT_EN adds an abort input that returns a busy sequence to IDLE.
module fpdiv_seq_ctrl #(
    parameter int unsigned ITERS = 3,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef FPDIV_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             en_a,
    output logic             en_b,
    output logic             en_rem,
    output logic [1:0]       sel_mux3,
    output logic [1:0]       sel_mux4,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT_N = 3'd1,
        S_INIT_D = 3'd2,
        S_ITER_N = 3'd3,
        S_ITER_D = 3'd4,
        S_REM    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             abort_s;
    logic             busy_d, done_d, en_a_d, en_b_d, en_rem_d;
    logic [1:0]       sel3_d, sel4_d;

`ifdef FPDIV_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state and iteration counter; abort only applies while the datapath is being driven.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        if (abort_s && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = start ? S_INIT_N : S_IDLE;
                S_INIT_N: state_d = S_INIT_D;
                S_INIT_D: begin
                    state_d = S_ITER_N;
                    iter_d  = {CNT_W{1'b0}};
                end
                S_ITER_N: state_d = S_ITER_D;
                S_ITER_D: begin
                    iter_d  = iter_q + CNT_W'(1);
                    state_d = (iter_q == LAST_ITER) ? S_REM : S_ITER_N;
                end
                S_REM:    state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Moore decode of the upcoming state so every output leaves a flop.
    always_comb begin
        busy_d   = 1'b1;
        done_d   = 1'b0;
        en_a_d   = 1'b0;
        en_b_d   = 1'b0;
        en_rem_d = 1'b0;
        sel3_d   = 2'd0;
        sel4_d   = 2'd0;
        case (state_d)
            S_IDLE:   busy_d = 1'b0;
            S_INIT_N: en_a_d = 1'b1;
            S_INIT_D: begin
                en_b_d = 1'b1;
                sel4_d = 2'd1;
            end
            // ITER_N must come first: both halves read the regc value from before en_b.
            S_ITER_N: begin
                en_a_d = 1'b1;
                sel3_d = 2'd1;
                sel4_d = 2'd2;
            end
            S_ITER_D: begin
                en_b_d = 1'b1;
                sel3_d = 2'd1;
                sel4_d = 2'd3;
            end
            S_REM: begin
                en_rem_d = 1'b1;
                sel3_d   = 2'd2;
                sel4_d   = 2'd2;
            end
            S_DONE:   done_d = 1'b1;
            default:  busy_d = 1'b0;
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            iter_q   <= {CNT_W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            en_a     <= 1'b0;
            en_b     <= 1'b0;
            en_rem   <= 1'b0;
            sel_mux3 <= 2'd0;
            sel_mux4 <= 2'd0;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            busy     <= busy_d;
            done     <= done_d;
            en_a     <= en_a_d;
            en_b     <= en_b_d;
            en_rem   <= en_rem_d;
            sel_mux3 <= sel3_d;
            sel_mux4 <= sel4_d;
        end
    end

    assign iter = iter_q;

endmodule

// File: tb/tb_fpdiv_seq_ctrl.sv
// Self-checking bench for fpdiv_seq_ctrl: directed scenarios plus random start/reset traffic
// compared every cycle against a model that tracks only elapsed cycles since the accepted start.
module tb_fpdiv_seq_ctrl;

    localparam int ITERS = 3;
    localparam int CNT_W = 4;
    localparam int T_REM  = 2 * ITERS + 3;
    localparam int T_DONE = 2 * ITERS + 4;

    logic             clk = 1'b0;
    logic             reset, start, abort_tb;
    logic             busy, done, en_a, en_b, en_rem;
    logic [1:0]       sel_mux3, sel_mux4;
    logic [CNT_W-1:0] iter;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;   // cycles since accepted start, 0 = idle
    int last_iter = 0;

    always #5 clk = ~clk;

    fpdiv_seq_ctrl #(.ITERS(ITERS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef FPDIV_SEQ_ABORT_EN
        .abort(abort_tb),
`endif
        .busy(busy), .done(done), .en_a(en_a), .en_b(en_b), .en_rem(en_rem),
        .sel_mux3(sel_mux3), .sel_mux4(sel_mux4), .iter(iter)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
    endtask

    // Expected {busy,done,en_a,en_b,en_rem,sel3,sel4} for t cycles into an operation.
    function automatic logic [8:0] exp_vec(input int tt);
        if (tt == 0)            return 9'b0_0_000_00_00;
        else if (tt == 1)       return 9'b1_0_100_00_00;
        else if (tt == 2)       return 9'b1_0_010_00_01;
        else if (tt < T_REM)    return ((tt - 3) % 2 == 0) ? 9'b1_0_100_01_10 : 9'b1_0_010_01_11;
        else if (tt == T_REM)   return 9'b1_0_001_10_10;
        else                    return 9'b1_1_000_00_00;
    endfunction

    // One clock: drive inputs at negedge, advance model at posedge, compare just after.
    task automatic step(input logic st, input logic rs, input logic ab);
        @(negedge clk);
        start = st; reset = rs; abort_tb = ab;
        @(posedge clk);
        if (rs) begin
            t = 0; last_iter = 0;
        end else if (t == 0) begin
            t = st ? 1 : 0;
        end else if (ab && t <= T_REM) begin
            t = 0;
        end else if (t == T_DONE) begin
            t = 0;
        end else begin
            t = t + 1;
        end
        if (!rs) begin
            if (t >= 3 && t < T_REM) last_iter = (t - 3) / 2;
            else if (t >= T_REM)     last_iter = ITERS;
        end
        #1;
        chk("outs", {23'd0, busy, done, en_a, en_b, en_rem, sel_mux3, sel_mux4}, {23'd0, exp_vec(t)});
        chk("iter", {28'd0, iter}, last_iter);
    endtask

    // Start an operation and measure cycles until done (optionally with ignored start pulses).
    task automatic run_one(input bit spurious);
        int n;
        step(1'b1, 1'b0, 1'b0);
        n = 1;
        while (!done && n <= 40) begin
            step(spurious && (t == 2), 1'b0, 1'b0);
            n++;
        end
        chk("latency", n, T_DONE);
        step(spurious, 1'b0, 1'b0);     // start during DONE
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int c, prev_done, gap;
        start = 1'b0; reset = 1'b1; abort_tb = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        step(1'b0, 1'b0, 1'b0);

        run_one(1'b0);
        step(1'b0, 1'b0, 1'b0);

        // start held high: dones separated by one IDLE cycle
        prev_done = -1;
        for (c = 0; c < 40; c++) begin
            step(1'b1, 1'b0, 1'b0);
            if (done) begin
                if (prev_done >= 0) begin
                    gap = c - prev_done;
                    chk("b2b_gap", gap, T_DONE + 1);
                end
                prev_done = c;
            end
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // reset during ITER_D of the first iteration, then a clean run
        step(1'b1, 1'b0, 1'b0);
        for (c = 0; c < 20 && t != 4; c++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        run_one(1'b0);

        run_one(1'b1);
        step(1'b0, 1'b0, 1'b0);

        // random traffic
        for (c = 0; c < 400; c++) begin
            logic ab;
`ifdef FPDIV_SEQ_ABORT_EN
            ab = ($urandom_range(0, 15) == 0);
`else
            ab = 1'b0;
`endif
            step($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
